// File: rtl/riscv_v_alu_sequencer.sv
// Vector ALU sequencer: walks the register groups of one instruction through the ALU, with per-group or reduced writeback.
// Optional performance counters are enabled with RISCV_V_ALU_SEQ_PERF_CNT_EN.
module riscv_v_alu_sequencer #(
    parameter int NUM_BYTES  = 16,
    parameter int MAX_GROUPS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [5:0]             req_opcode,
    input  logic [2:0]             req_osize,
    input  logic                   req_is_reduct,
    input  logic [3:0]             req_lmul,
    output logic                   alu_valid,
    output logic [5:0]             alu_opcode,
    output logic [2:0]             alu_osize,
    output logic                   alu_is_reduct,
    output logic [2:0]             alu_group,
    output logic                   alu_use_acc,
    output logic [NUM_BYTES*8-1:0] acc_data,
    input  logic [NUM_BYTES*8-1:0] alu_result,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [2:0]             wb_group,
    output logic [NUM_BYTES*8-1:0] wb_data,
    output logic                   wb_last,
    output logic                   busy
`ifdef RISCV_V_ALU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]            perf_instr_cnt,
    output logic [31:0]            perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] g;
    logic [3:0] lmul_r;
    logic [5:0] opcode_r;
    logic [2:0] osize_r;
    logic       reduct_r;
    logic [3:0] eff_lmul;
    logic       last_group;
    logic       in_issue;

    // A zero group count means one group; anything above the maximum is clamped.
    always_comb begin
        eff_lmul = req_lmul;
        if (req_lmul == 4'd0) begin
            eff_lmul = 4'd1;
        end else if (req_lmul > 4'(MAX_GROUPS)) begin
            eff_lmul = 4'(MAX_GROUPS);
        end
    end

    assign last_group = (g == 3'(lmul_r - 4'd1));
    assign in_issue   = (state == ISSUE);

    assign req_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign wb_valid      = (state == WB);
    assign alu_valid     = in_issue;
    assign alu_opcode    = in_issue ? opcode_r : 6'd0;
    assign alu_osize     = in_issue ? osize_r : 3'd0;
    assign alu_is_reduct = in_issue & reduct_r;
    assign alu_group     = in_issue ? g : 3'd0;
    assign alu_use_acc   = in_issue & reduct_r & (g != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            g        <= 3'd0;
            lmul_r   <= 4'd0;
            opcode_r <= 6'd0;
            osize_r  <= 3'd0;
            reduct_r <= 1'b0;
            acc_data <= '0;
            wb_data  <= '0;
            wb_group <= 3'd0;
            wb_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        opcode_r <= req_opcode;
                        osize_r  <= req_osize;
                        reduct_r <= req_is_reduct;
                        lmul_r   <= eff_lmul;
                        g        <= 3'd0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (reduct_r) begin
                        // Reductions stream one group per cycle and only write back the final sum.
                        acc_data <= alu_result;
                        if (last_group) begin
                            wb_data  <= alu_result;
                            wb_group <= 3'd0;
                            wb_last  <= 1'b1;
                            state    <= WB;
                        end else begin
                            g <= g + 3'd1;
                        end
                    end else begin
                        wb_data  <= alu_result;
                        wb_group <= g;
                        wb_last  <= last_group;
                        state    <= WB;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        if (last_group) begin
                            state <= IDLE;
                        end else begin
                            g     <= g + 3'd1;
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RISCV_V_ALU_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_instr_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else if (state == WB) begin
            if (!wb_ready) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end else if (last_group) begin
                perf_instr_cnt <= perf_instr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
